// File: rtl/nibble_pack_ctrl.sv
// Nibble-to-word packing controller: gathers NUM_NIB LSB/MSB nibble pairs over a
// valid/ready handshake and presents the packed word pair over a second handshake.
module nibble_pack_ctrl #(
    parameter int NIB_W      = 4,
    parameter int NUM_NIB    = 8,
    parameter int AUTO_REARM = 0,
    localparam int WORD_W    = NIB_W * NUM_NIB,
    localparam int CNT_W     = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1
) (
    input  logic              pclk,
    input  logic              RESET_n,
    input  logic              start,
    input  logic [NIB_W-1:0]  LSBs,
    input  logic [NIB_W-1:0]  MSBs,
    input  logic              pValid,
    output logic              pReady,
    output logic [WORD_W-1:0] chip_value_LSBs,
    output logic [WORD_W-1:0] chip_value_MSBs,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  nib_count,
    output logic              err_start,
    input  logic              clr_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_NIB - 1);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   sh_l_q, sh_l_d;
    logic [WORD_W-1:0]   sh_m_q, sh_m_d;
    logic [WORD_W-1:0]   chip_l_q, chip_l_d;
    logic [WORD_W-1:0]   chip_m_q, chip_m_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [WORD_W-1:0]   sh_l_next;
    logic [WORD_W-1:0]   sh_m_next;

    // New nibbles enter at the top so the first beat ends up in the lowest nibble.
    assign sh_l_next = {LSBs, sh_l_q[WORD_W-1:NIB_W]};
    assign sh_m_next = {MSBs, sh_m_q[WORD_W-1:NIB_W]};

    always_comb begin
        state_d  = state_q;
        sh_l_d   = sh_l_q;
        sh_m_d   = sh_m_q;
        chip_l_d = chip_l_q;
        chip_m_d = chip_m_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        // A set in the same cycle overrides this clear (assigned later below).
        if (clr_err) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    sh_l_d  = '0;
                    sh_m_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_FILL: begin
                if (start) begin
                    err_d = 1'b1;
                end
                if (pValid) begin
                    sh_l_d = sh_l_next;
                    sh_m_d = sh_m_next;
                    if (cnt_q == LAST_BEAT) begin
                        chip_l_d = sh_l_next;
                        chip_m_d = sh_m_next;
                        cnt_d    = '0;
                        state_d  = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (start) begin
                    err_d = 1'b1;
                end
                if (word_ready) begin
                    state_d = (AUTO_REARM != 0) ? S_FILL : S_IDLE;
                    sh_l_d  = '0;
                    sh_m_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= S_IDLE;
            sh_l_q   <= '0;
            sh_m_q   <= '0;
            chip_l_q <= '0;
            chip_m_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_l_q   <= sh_l_d;
            sh_m_q   <= sh_m_d;
            chip_l_q <= chip_l_d;
            chip_m_q <= chip_m_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Handshake outputs are pure decodes of the state register, so no input reaches them.
    assign pReady          = (state_q == S_FILL);
    assign word_valid      = (state_q == S_HOLD);
    assign busy            = (state_q != S_IDLE);
    assign nib_count       = cnt_q;
    assign err_start       = err_q;
    assign chip_value_LSBs = chip_l_q;
    assign chip_value_MSBs = chip_m_q;

endmodule

// File: tb/tb_nibble_pack_ctrl.sv
// Directed bench for nibble_pack_ctrl: one instance with AUTO_REARM=0, one with AUTO_REARM=1.
module tb_nibble_pack_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start0, start1;
    logic [3:0]  lsbs, msbs;
    logic        pvalid0, pvalid1;
    logic        wready0, wready1;
    logic        clr_err;

    logic        pready0, pready1;
    logic [31:0] chip_l0, chip_m0, chip_l1, chip_m1;
    logic        wvalid0, wvalid1;
    logic        busy0, busy1;
    logic [2:0]  cnt0, cnt1;
    logic        err0, err1;

    int n_assert;
    int n_fail;
    int cyc;

    nibble_pack_ctrl #(.NIB_W(4), .NUM_NIB(8), .AUTO_REARM(0)) dut0 (
        .pclk(clk), .RESET_n(rst_n), .start(start0), .LSBs(lsbs), .MSBs(msbs),
        .pValid(pvalid0), .pReady(pready0), .chip_value_LSBs(chip_l0),
        .chip_value_MSBs(chip_m0), .word_valid(wvalid0), .word_ready(wready0),
        .busy(busy0), .nib_count(cnt0), .err_start(err0), .clr_err(clr_err)
    );

    nibble_pack_ctrl #(.NIB_W(4), .NUM_NIB(8), .AUTO_REARM(1)) dut1 (
        .pclk(clk), .RESET_n(rst_n), .start(start1), .LSBs(lsbs), .MSBs(msbs),
        .pValid(pvalid1), .pReady(pready1), .chip_value_LSBs(chip_l1),
        .chip_value_MSBs(chip_m1), .word_valid(wvalid1), .word_ready(wready1),
        .busy(busy1), .nib_count(cnt1), .err_start(err1), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start0   = 0; start1 = 0;
        pvalid0  = 0; pvalid1 = 0;
        wready0  = 0; wready1 = 0;
        clr_err  = 0;
        lsbs     = 0; msbs = 0;

        // Reset state
        tick(); tick();
        check("rst_pready", 32'(pready0), 32'd0);
        check("rst_wvalid", 32'(wvalid0), 32'd0);
        check("rst_busy",   32'(busy0),   32'd0);
        check("rst_cnt",    32'(cnt0),    32'd0);
        check("rst_err",    32'(err0),    32'd0);
        check("rst_chip_l", chip_l0,      32'd0);
        check("rst_chip_m", chip_m0,      32'd0);
        check("rst_busy1",  32'(busy1),   32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_pready", 32'(pready0), 32'd0);

        // Test 1: eight back-to-back beats
        start0 = 1; tick(); start0 = 0;
        check("t1_fill_pready", 32'(pready0), 32'd1);
        check("t1_fill_busy",   32'(busy0),   32'd1);
        pvalid0 = 1;
        for (int i = 0; i < 8; i++) begin
            lsbs = 4'(i); msbs = 4'(15 - i);
            tick();
            if (i == 3) check("t1_cnt4", 32'(cnt0), 32'd4);
            if (i == 6) check("t1_wvalid_early", 32'(wvalid0), 32'd0);
        end
        pvalid0 = 0;
        check("t1_wvalid", 32'(wvalid0), 32'd1);
        check("t1_pready", 32'(pready0), 32'd0);
        check("t1_chip_l", chip_l0, 32'h76543210);
        check("t1_chip_m", chip_m0, 32'h89ABCDEF);
        check("t1_cnt0",   32'(cnt0), 32'd0);

        // Test 3: consumer stalls for 10 cycles, source keeps offering data
        pvalid0 = 1; lsbs = 4'h5; msbs = 4'h5;
        for (int i = 0; i < 10; i++) tick();
        pvalid0 = 0;
        check("t3_pready",  32'(pready0), 32'd0);
        check("t3_wvalid",  32'(wvalid0), 32'd1);
        check("t3_chip_l",  chip_l0, 32'h76543210);
        check("t3_chip_m",  chip_m0, 32'h89ABCDEF);
        wready0 = 1; tick(); wready0 = 0;
        check("t3_idle_busy",   32'(busy0),   32'd0);
        check("t3_idle_wvalid", 32'(wvalid0), 32'd0);
        check("t3_idle_hold_l", chip_l0, 32'h76543210);

        // Test 2: pValid alternating 0/1 from the first FILL cycle
        start0 = 1; tick(); start0 = 0;
        cyc = 0;
        while (!wvalid0 && cyc < 40) begin
            pvalid0 = cyc[0];
            lsbs = 4'(cyc / 2); msbs = 4'(15 - cyc / 2);
            tick();
            cyc++;
        end
        pvalid0 = 0;
        check("t2_latency", 32'(cyc), 32'd16);
        check("t2_chip_l",  chip_l0, 32'h76543210);
        check("t2_chip_m",  chip_m0, 32'h89ABCDEF);
        wready0 = 1; tick(); wready0 = 0;
        check("t2_idle", 32'(busy0), 32'd0);

        // Test 5: start during FILL sets the sticky error without disturbing capture
        start0 = 1; tick(); start0 = 0;
        pvalid0 = 1;
        for (int i = 0; i < 8; i++) begin
            lsbs = 4'(i + 8); msbs = 4'(7 - i);
            start0 = (i == 3);
            tick();
            start0 = 0;
            if (i == 3) begin
                check("t5_err_set", 32'(err0), 32'd1);
                check("t5_cnt4",    32'(cnt0), 32'd4);
            end
        end
        pvalid0 = 0;
        check("t5_chip_l",  chip_l0, 32'hFEDCBA98);
        check("t5_chip_m",  chip_m0, 32'h01234567);
        check("t5_err_hold", 32'(err0), 32'd1);
        clr_err = 1; tick(); clr_err = 0;
        check("t5_err_clr", 32'(err0), 32'd0);
        start0 = 1; clr_err = 1; tick(); start0 = 0; clr_err = 0;
        check("t5_set_wins", 32'(err0), 32'd1);
        check("t5_hold_stays", 32'(wvalid0), 32'd1);
        wready0 = 1; tick(); wready0 = 0;
        check("t5_idle_err", 32'(err0), 32'd1);
        start0 = 1; clr_err = 1; tick(); start0 = 0; clr_err = 0;
        check("t5_idle_both_err",  32'(err0),  32'd0);
        check("t5_idle_both_busy", 32'(busy0), 32'd1);

        // Test 6: asynchronous reset in the middle of a word
        pvalid0 = 1; lsbs = 4'hA; msbs = 4'h5;
        for (int i = 0; i < 5; i++) tick();
        pvalid0 = 0;
        check("t6_cnt5", 32'(cnt0), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy",   32'(busy0),   32'd0);
        check("t6_pready", 32'(pready0), 32'd0);
        check("t6_cnt",    32'(cnt0),    32'd0);
        check("t6_chip_l", chip_l0,      32'd0);
        check("t6_chip_m", chip_m0,      32'd0);
        rst_n = 1'b1;
        tick();
        start0 = 1; tick(); start0 = 0;
        pvalid0 = 1;
        for (int i = 0; i < 8; i++) begin
            lsbs = 4'(i + 1); msbs = 4'h0;
            tick();
        end
        pvalid0 = 0;
        check("t6_wvalid", 32'(wvalid0), 32'd1);
        check("t6_chip_l", chip_l0, 32'h87654321);
        check("t6_chip_m", chip_m0, 32'h00000000);

        // Test 4: AUTO_REARM instance, two words without a second start
        start1 = 1; tick(); start1 = 0;
        pvalid1 = 1; lsbs = 4'h1; msbs = 4'h1;
        for (int i = 0; i < 8; i++) tick();
        check("t4_w1_valid", 32'(wvalid1), 32'd1);
        check("t4_w1_l", chip_l1, 32'h11111111);
        check("t4_w1_m", chip_m1, 32'h11111111);
        lsbs = 4'h2; msbs = 4'h2;
        wready1 = 1; tick(); wready1 = 0;
        check("t4_rearm_pready", 32'(pready1), 32'd1);
        check("t4_rearm_cnt",    32'(cnt1),    32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("t4_mid_hold_l", chip_l1, 32'h11111111);
        for (int i = 0; i < 4; i++) tick();
        pvalid1 = 0;
        check("t4_w2_valid", 32'(wvalid1), 32'd1);
        check("t4_w2_l", chip_l1, 32'h22222222);
        check("t4_w2_m", chip_m1, 32'h22222222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
